// File: rtl/regfile_scoreboard.sv
// 32-entry register file with a per-register pending-write scoreboard.
// Decode reads bypassed operands and gets a stall while any source or a saturated destination is still pending.
module regfile_scoreboard #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NREG     = 32,
    parameter int MAX_PEND = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    input  logic              use_rs,
    input  logic              use_rt,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    input  logic              issue_valid,
    input  logic              issue_wr,
    input  logic [ADDR_W-1:0] issue_dst,
    output logic              stall,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              err
);

    localparam int CNT_W = $clog2(MAX_PEND + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_PEND);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [DATA_W-1:0] regs    [NREG];
    logic [CNT_W-1:0]  cnt     [NREG];
    logic [CNT_W-1:0]  cnt_nxt [NREG];
    logic              err_nxt;

    logic rs_wb_hit, rt_wb_hit, dst_wb_hit;
    logic rs_busy, rt_busy, dst_full;
    logic accept_wr;

    assign rs_wb_hit  = wb_en && (wb_addr == rs_addr);
    assign rt_wb_hit  = wb_en && (wb_addr == rt_addr);
    assign dst_wb_hit = wb_en && (wb_addr == issue_dst);

    // Write-through bypass; register 0 always reads as zero.
    always_comb begin
        rs_data = regs[rs_addr];
        if (rs_addr == '0)
            rs_data = '0;
        else if (rs_wb_hit)
            rs_data = wb_data;

        rt_data = regs[rt_addr];
        if (rt_addr == '0)
            rt_data = '0;
        else if (rt_wb_hit)
            rt_data = wb_data;
    end

    // A source whose last pending write retires this cycle is served by the bypass.
    assign rs_busy  = (cnt[rs_addr] != '0) && !((cnt[rs_addr] == CNT_ONE) && rs_wb_hit);
    assign rt_busy  = (cnt[rt_addr] != '0) && !((cnt[rt_addr] == CNT_ONE) && rt_wb_hit);
    assign dst_full = issue_wr && (issue_dst != '0) && (cnt[issue_dst] == CNT_MAX) && !dst_wb_hit;

    assign stall     = issue_valid && ((use_rs && rs_busy) || (use_rt && rt_busy) || dst_full);
    assign accept_wr = issue_valid && !stall && issue_wr && (issue_dst != '0);

    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            cnt_nxt[i] = cnt[i];
            if (i != 0) begin
                // Simultaneous reserve and retire leaves the count unchanged; retire clamps at zero.
                case ({accept_wr && (issue_dst == ADDR_W'(i)),
                       wb_en && (wb_addr == ADDR_W'(i)) && (cnt[i] != '0)})
                    2'b10:   cnt_nxt[i] = cnt[i] + CNT_ONE;
                    2'b01:   cnt_nxt[i] = cnt[i] - CNT_ONE;
                    default: cnt_nxt[i] = cnt[i];
                endcase
            end
        end
    end

    assign err_nxt = err || (wb_en && (wb_addr != '0) && (cnt[wb_addr] == '0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
                cnt[i]  <= '0;
            end
            err <= 1'b0;
        end else begin
            if (wb_en && (wb_addr != '0))
                regs[wb_addr] <= wb_data;
            for (int i = 0; i < NREG; i++)
                cnt[i] <= cnt_nxt[i];
            err <= err_nxt;
        end
    end

endmodule
